bp_be_acc_dispatch: RTL and testbench
=====================================

# bp_be_acc_dispatch

Multi-channel accelerator command dispatcher in the BE calculator, fed from the system pipe's retire stage. It captures retired RISC-V custom-opcode instructions with their operand and routes each to one of up to four accelerator channels. Each channel has its own FIFO, valid/ready handshake and outstanding-response counter. Status outputs give back-pressure to the issue stage and an idle indication for fences.

## Interface
Parameters:
- num_acc_p, 1: channel count, 1..4; channel c maps to custom opcode c.
- fifo_els_p, 4: per-channel FIFO depth, power of 2, >= 4.
- max_outstanding_p, 8: per-channel limit on issued-but-unanswered commands, >= 1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- retire_v_i  in  1  retire stage valid.
- retire_queue_v_i  in  1  retiring instruction was queued (not a bubble or replay).
- retire_exception_v_i  in  1  retiring instruction raised any exception.
- retire_instr_i  in  32  retiring instruction.
- retire_data_i  in  64  operand (rs1+imm).
- acc_v_o  out  num_acc_p  per-channel command valid.
- acc_ready_i  in  num_acc_p  per-channel accelerator ready.
- acc_instr_o  out  num_acc_p*32  per-channel instruction; channel c at [32c+:32].
- acc_data_o  out  num_acc_p*64  per-channel operand; channel c at [64c+:64].
- acc_resp_v_i  in  num_acc_p  per-channel completion pulse.
- acc_busy_o  out  num_acc_p  channel near full; issue must hold further commands to that channel.
- idle_o  out  1  no buffered, in-flight or outstanding commands.
- overflow_o  out  1  sticky: an enqueue hit a full FIFO.

## Operation
- Opcode map:
  - custom0 7'b0001011 -> channel 0.
  - custom1 7'b0101011 -> channel 1.
  - custom2 7'b1011011 -> channel 2.
  - custom3 7'b1111011 -> channel 3.
  - Any channel >= num_acc_p is ignored.
- Capture condition: retire_v_i & retire_queue_v_i & ~retire_exception_v_i & mapped opcode.
  - On capture, {instr, data} and the channel index are written to a one-entry input register.
  - The next cycle, that register is pushed into the channel FIFO.
  - Retired commands are committed; no flush or squash input exists.
- Dispatch: acc_v_o[c] = FIFO[c] non-empty & outstanding[c] < max_outstanding_p.
  - acc_instr_o and acc_data_o present FIFO head. They are held stable while acc_v_o[c] & ~acc_ready_i[c].
  - Handshake pops the FIFO and increments outstanding[c].
- Response: acc_resp_v_i[c] decrements outstanding[c].
  - A response at zero is ignored; the counter does not wrap.
  - Handshake and response on the same channel in the same cycle leave the counter unchanged.
- Back-pressure: acc_busy_o[c] = count[c] >= fifo_els_p-2, which covers the two commands that can be in flight behind issue.
- Full FIFO push:
  - If the FIFO also pops that cycle, the push is accepted.
  - Otherwise the command is dropped and overflow_o sets. It stays set until reset.
- idle_o = input register empty & all FIFOs empty & all outstanding counters zero.
- Reset (asynchronous assert, synchronous-safe deassert): FIFOs empty, counters 0, input register invalid, overflow_o 0. Resulting output values: acc_v_o 0, acc_busy_o 0, idle_o 1.
  - Reset asserted mid-operation discards all buffered commands immediately.

## Timing
- Latency: retire in cycle N -> input register in N+1 -> FIFO head; acc_v_o rises in N+2 when the FIFO was empty and the channel is not at its limit.
- Throughput: one capture per cycle across all channels; one dispatch per cycle per channel.
- acc_busy_o and idle_o are combinational from registered state only, with no input-to-output paths.
- acc_instr_o and acc_data_o come from FIFO storage. They are don't-care when acc_v_o is 0.

## Structure
- bp_be_pkg additions:
  - opcode constants RV64_CUSTOM0..3_OP.
  - bp_be_acc_cmd_s {instr[31:0], data[63:0]}, 96 bits.
- Sub-module bp_be_acc_fifo: 1r1w, parametrised els/width, asynchronous active-low reset, with count output. Instantiate num_acc_p copies in a generate loop.
- Outstanding counters: width $clog2(max_outstanding_p+1).

## Test plan
- Reset: hold reset_n_i low mid-traffic -> acc_v_o=0, idle_o=1, overflow_o=0 immediately.
- Single command: retire custom0 with data 64'hDEAD_BEEF at cycle N, acc_ready_i=1 -> acc_v_o[0] high exactly in N+2 with data DEAD_BEEF; idle_o returns to 1 only after acc_resp_v_i[0].
- Filtering: retire custom1 with retire_exception_v_i=1, then custom2 with num_acc_p=2 -> no enqueue, idle_o stays 1.
- Back-pressure and overflow: fifo_els_p=4, acc_ready_i=0, 3 commands -> acc_busy_o[0]=1 after the 2nd push; 5 commands -> overflow_o=1 and the FIFO holds exactly commands 1-4 in order.
- Outstanding limit: max_outstanding_p=2, 3 commands, no responses -> only 2 handshakes; one acc_resp_v_i pulse releases the 3rd.
- Concurrency: handshake and response on channel 1 in the same cycle -> counter unchanged; interleaved traffic on channels 0-3 -> per-channel order preserved.

Source files
------------

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - BE calculator shared types for the accelerator command path
package bp_be_pkg;

  // RISC-V custom opcode space, one opcode per accelerator channel
  localparam logic [6:0] RV64_CUSTOM0_OP = 7'b0001011;
  localparam logic [6:0] RV64_CUSTOM1_OP = 7'b0101011;
  localparam logic [6:0] RV64_CUSTOM2_OP = 7'b1011011;
  localparam logic [6:0] RV64_CUSTOM3_OP = 7'b1111011;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] data;
  } bp_be_acc_cmd_s;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
  } bp_be_acc_sel_s;

  // Map an opcode to its accelerator channel; v=0 for non-custom opcodes
  function automatic bp_be_acc_sel_s acc_chan_decode(input logic [6:0] opcode);
    bp_be_acc_sel_s sel;
    sel = '0;
    unique case (opcode)
      RV64_CUSTOM0_OP: sel = '{v: 1'b1, ch: 2'd0};
      RV64_CUSTOM1_OP: sel = '{v: 1'b1, ch: 2'd1};
      RV64_CUSTOM2_OP: sel = '{v: 1'b1, ch: 2'd2};
      RV64_CUSTOM3_OP: sel = '{v: 1'b1, ch: 2'd3};
      default:         sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bp_be_acc_fifo.sv
// rtl/bp_be_acc_fifo.sv - 1r1w FIFO with occupancy count, one per accelerator channel
module bp_be_acc_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 96
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         yumi_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  output logic                         full_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push, pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign pop     = yumi_i & v_o;
  assign push    = v_i & (~full_o | pop);
  assign v_o     = (count_q != '0);
  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next state; depth is a power of two so pointers wrap naturally
  always_comb begin
    wptr_d  = push ? wptr_q + ptr_w_lp'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + ptr_w_lp'(1) : rptr_q;
    count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries are only read once written
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_be_acc_dispatch.sv
// rtl/bp_be_acc_dispatch.sv - routes retired custom-opcode instructions to accelerator channels
module bp_be_acc_dispatch
  import bp_be_pkg::*;
#(
  parameter int num_acc_p         = 1,
  parameter int fifo_els_p        = 4,
  parameter int max_outstanding_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    retire_v_i,
  input  logic                    retire_queue_v_i,
  input  logic                    retire_exception_v_i,
  input  logic [31:0]             retire_instr_i,
  input  logic [63:0]             retire_data_i,
  output logic [num_acc_p-1:0]    acc_v_o,
  input  logic [num_acc_p-1:0]    acc_ready_i,
  output logic [num_acc_p*32-1:0] acc_instr_o,
  output logic [num_acc_p*64-1:0] acc_data_o,
  input  logic [num_acc_p-1:0]    acc_resp_v_i,
  output logic [num_acc_p-1:0]    acc_busy_o,
  output logic                    idle_o,
  output logic                    overflow_o
);

  localparam int cnt_w_lp = $clog2(fifo_els_p+1);
  localparam int out_w_lp = $clog2(max_outstanding_p+1);

  bp_be_acc_sel_s sel;
  logic           capture;
  logic           in_v_q;
  logic [1:0]     in_ch_q;
  bp_be_acc_cmd_s in_cmd_q;
  logic           ovf_q, ovf_d;
  logic [num_acc_p-1:0] drop, chan_idle, acc_v;

  assign sel     = acc_chan_decode(retire_instr_i[6:0]);
  assign capture = retire_v_i & retire_queue_v_i & ~retire_exception_v_i
                 & sel.v & (int'(sel.ch) < num_acc_p);

  // One-entry input register between retire and the channel FIFOs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_v_q   <= 1'b0;
      in_ch_q  <= '0;
      in_cmd_q <= '0;
    end else begin
      in_v_q <= capture;
      if (capture) begin
        in_ch_q  <= sel.ch;
        in_cmd_q <= '{instr: retire_instr_i, data: retire_data_i};
      end
    end
  end

  for (genvar c = 0; c < num_acc_p; c++) begin : g_chan
    logic                push, pop, fifo_v, full, resp_dec;
    bp_be_acc_cmd_s      head;
    logic [cnt_w_lp-1:0] count;
    logic [out_w_lp-1:0] out_q, out_d;

    assign push = in_v_q & (in_ch_q == 2'(c));

    bp_be_acc_fifo #(
      .els_p  (fifo_els_p),
      .width_p($bits(bp_be_acc_cmd_s))
    ) fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (push),
      .data_i   (in_cmd_q),
      .yumi_i   (pop),
      .v_o      (fifo_v),
      .data_o   (head),
      .full_o   (full),
      .count_o  (count)
    );

    assign acc_v[c]               = fifo_v & (out_q < out_w_lp'(max_outstanding_p));
    assign pop                    = acc_v[c] & acc_ready_i[c];
    assign drop[c]                = push & full & ~pop;
    assign acc_instr_o[32*c +: 32] = head.instr;
    assign acc_data_o[64*c +: 64]  = head.data;
    assign acc_busy_o[c]          = (count >= cnt_w_lp'(fifo_els_p-2));
    assign resp_dec               = acc_resp_v_i[c] & (out_q != '0);
    assign chan_idle[c]           = ~fifo_v & (out_q == '0);

    // Outstanding count: issue adds one, a response removes one unless nothing is outstanding
    always_comb begin
      out_d = out_q;
      if (pop & ~resp_dec)      out_d = out_q + out_w_lp'(1);
      else if (~pop & resp_dec) out_d = out_q - out_w_lp'(1);
    end

    // Outstanding counter register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) out_q <= '0;
      else            out_q <= out_d;
    end
  end

  assign acc_v_o = acc_v;

  // Sticky overflow flag
  always_comb ovf_d = ovf_q | (|drop);

  // Overflow register, cleared only by reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  assign overflow_o = ovf_q;
  assign idle_o     = ~in_v_q & (&chan_idle);

endmodule

// File: tb/tb_bp_be_acc_dispatch.sv
// tb/tb_bp_be_acc_dispatch.sv - randomized and directed check of the accelerator dispatcher
module tb_bp_be_acc_dispatch;

  localparam int NA   = 3;
  localparam int ELS  = 4;
  localparam int MAXO = 2;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             retire_v_i, retire_queue_v_i, retire_exception_v_i;
  logic [31:0]      retire_instr_i;
  logic [63:0]      retire_data_i;
  logic [NA-1:0]    acc_v_o, acc_ready_i, acc_resp_v_i, acc_busy_o;
  logic [NA*32-1:0] acc_instr_o;
  logic [NA*64-1:0] acc_data_o;
  logic             idle_o, overflow_o;

  bp_be_acc_dispatch #(
    .num_acc_p(NA), .fifo_els_p(ELS), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .retire_v_i(retire_v_i), .retire_queue_v_i(retire_queue_v_i),
    .retire_exception_v_i(retire_exception_v_i),
    .retire_instr_i(retire_instr_i), .retire_data_i(retire_data_i),
    .acc_v_o(acc_v_o), .acc_ready_i(acc_ready_i),
    .acc_instr_o(acc_instr_o), .acc_data_o(acc_data_o),
    .acc_resp_v_i(acc_resp_v_i), .acc_busy_o(acc_busy_o),
    .idle_o(idle_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // reference model: per-channel command queues, outstanding counts, pending capture
  logic [95:0] mq [NA][$];
  int          mo [NA];
  bit          pv;
  int          pch;
  logic [95:0] pcmd;
  bit          movf;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int chan_of(input logic [6:0] op);
    case (op)
      7'b0001011: return 0;
      7'b0101011: return 1;
      7'b1011011: return 2;
      7'b1111011: return 3;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int ch);
    case (ch)
      0: return 7'b0001011;
      1: return 7'b0101011;
      2: return 7'b1011011;
      3: return 7'b1111011;
      4: return 7'b0110011;
      default: return 7'b0000011;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NA; c++) begin
      mq[c].delete();
      mo[c] = 0;
    end
    pv = 0; pch = 0; pcmd = '0; movf = 0;
  endtask

  task automatic check_outputs();
    bit idle_e;
    bit ve;
    idle_e = !pv;
    for (int c = 0; c < NA; c++) begin
      ve = (mq[c].size() > 0) && (mo[c] < MAXO);
      check($sformatf("acc_v%0d", c), 96'(acc_v_o[c]), 96'(ve));
      if (ve) begin
        check($sformatf("instr%0d", c), 96'(acc_instr_o[32*c +: 32]), 96'(mq[c][0][95:64]));
        check($sformatf("data%0d", c), 96'(acc_data_o[64*c +: 64]), 96'(mq[c][0][63:0]));
      end
      check($sformatf("busy%0d", c), 96'(acc_busy_o[c]), 96'(mq[c].size() >= ELS-2));
      if (mq[c].size() != 0 || mo[c] != 0) idle_e = 0;
    end
    check("idle", 96'(idle_o), 96'(idle_e));
    check("overflow", 96'(overflow_o), 96'(movf));
  endtask

  task automatic model_update();
    bit hs;
    int sz;
    int ch;
    for (int c = 0; c < NA; c++) begin
      hs = acc_ready_i[c] && (mq[c].size() > 0) && (mo[c] < MAXO);
      sz = mq[c].size();
      if (hs) void'(mq[c].pop_front());
      if (pv && pch == c) begin
        if (sz < ELS || hs) mq[c].push_back(pcmd);
        else movf = 1;
      end
      mo[c] = mo[c] + (hs ? 1 : 0) - ((acc_resp_v_i[c] && mo[c] > 0) ? 1 : 0);
    end
    pv = 0;
    ch = chan_of(retire_instr_i[6:0]);
    if (retire_v_i && retire_queue_v_i && !retire_exception_v_i && ch >= 0 && ch < NA) begin
      pv = 1; pch = ch; pcmd = {retire_instr_i, retire_data_i};
    end
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_retire(input bit v, input bit exc, input int ch, input logic [63:0] d);
    retire_v_i           = v;
    retire_queue_v_i     = v;
    retire_exception_v_i = exc;
    retire_instr_i       = {$urandom_range(0, 32'h01FF_FFFF), op_of(ch)};
    retire_data_i        = d;
  endtask

  task automatic quiet();
    set_retire(0, 0, 5, '0);
    acc_ready_i  = '0;
    acc_resp_v_i = '0;
  endtask

  task automatic drain();
    quiet();
    acc_ready_i  = '1;
    acc_resp_v_i = '1;
    repeat (24) step();
    quiet();
    step();
  endtask

  task automatic do_reset();
    quiet();
    reset_n_i = 1'b0;
    #2;
    check("rst_v", 96'(acc_v_o), 96'(0));
    check("rst_idle", 96'(idle_o), 96'(1));
    check("rst_ovf", 96'(overflow_o), 96'(0));
    check("rst_busy", 96'(acc_busy_o), 96'(0));
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    quiet();
    reset_n_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    do_reset();
    step();

    // single command latency and idle release by response
    set_retire(1, 0, 0, 64'hDEAD_BEEF);
    acc_ready_i = '1;
    step();
    set_retire(0, 0, 5, '0);
    check("lat_n1_v", 96'(acc_v_o[0]), 96'(0));
    step();
    check("lat_n2_v", 96'(acc_v_o[0]), 96'(1));
    check("lat_n2_data", 96'(acc_data_o[63:0]), 96'(64'hDEAD_BEEF));
    repeat (3) step();
    check("wait_resp_idle", 96'(idle_o), 96'(0));
    acc_resp_v_i[0] = 1'b1;
    step();
    acc_resp_v_i = '0;
    check("resp_idle", 96'(idle_o), 96'(1));

    // filtering: exception, out-of-range channel, non-custom opcode
    set_retire(1, 1, 1, 64'h11);
    step();
    set_retire(1, 0, 3, 64'h22);
    step();
    set_retire(1, 0, 4, 64'h33);
    step();
    set_retire(0, 0, 5, '0);
    step();
    check("filter_idle", 96'(idle_o), 96'(1));

    // back-pressure and overflow on channel 0 with the accelerator stalled
    quiet();
    for (int i = 1; i <= 5; i++) begin
      set_retire(1, 0, 0, 64'(i));
      step();
      if (i == 2) check("busy_after_push1", 96'(acc_busy_o[0]), 96'(0));
      if (i == 3) check("busy_after_push2", 96'(acc_busy_o[0]), 96'(1));
    end
    set_retire(0, 0, 5, '0);
    step();
    check("ovf_set", 96'(overflow_o), 96'(1));
    check("ovf_head", 96'(acc_data_o[63:0]), 96'(1));
    drain();
    check("ovf_sticky", 96'(overflow_o), 96'(1));

    // reset mid-traffic clears everything immediately
    set_retire(1, 0, 1, 64'hAA);
    step();
    set_retire(1, 0, 2, 64'hBB);
    step();
    do_reset();
    step();

    // outstanding limit of two
    acc_ready_i = '1;
    for (int i = 0; i < 3; i++) begin
      set_retire(1, 0, 0, 64'h100 + 64'(i));
      step();
    end
    set_retire(0, 0, 5, '0);
    repeat (4) step();
    check("limit_hold", 96'(acc_v_o[0]), 96'(0));
    acc_resp_v_i[0] = 1'b1;
    step();
    acc_resp_v_i = '0;
    check("limit_release", 96'(acc_v_o[0]), 96'(1));
    check("limit_third", 96'(acc_data_o[63:0]), 96'(64'h102));
    drain();

    // same-cycle handshake and response on channel 1
    quiet();
    acc_ready_i[1] = 1'b1;
    set_retire(1, 0, 1, 64'h201);
    step();
    set_retire(1, 0, 1, 64'h202);
    step();
    set_retire(0, 0, 5, '0);
    acc_ready_i[1] = 1'b0;
    step();
    acc_ready_i[1]  = 1'b1;
    acc_resp_v_i[1] = 1'b1;
    step();
    quiet();
    repeat (2) step();
    check("concur_idle", 96'(idle_o), 96'(0));
    drain();

    // randomized interleaved traffic across all channels
    for (int n = 0; n < 1500; n++) begin
      set_retire($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5), {$urandom, $urandom});
      retire_queue_v_i = retire_v_i & ($urandom_range(0, 9) != 0);
      acc_ready_i  = NA'($urandom);
      acc_resp_v_i = NA'($urandom) & NA'($urandom);
      step();
    end
    drain();
    check("final_idle", 96'(idle_o), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
